led_pattern_bank: RTL and testbench
===================================

Name: led_pattern_bank

Overview:
- Parametrised bank of N_CH independent LED drivers in the sys_clk domain. Generalises the fixed-period LED blinkers in the top level.
- Each channel is runtime-configurable as OFF, ON, BLINK (square wave) or PWM (period/duty).
- A shared prescaler provides the time base.
- New configurations are staged in shadow registers and committed glitch-free at the channel's period boundary.

Parameters:
- N_CH, 4: number of LED channels (1..16).
- CNT_W, 26: width of the period, duty and channel counters.
- PRESC_DIV, 50: sys_clk cycles per tick (>=1); the simulation top level uses 4.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_period  in  CNT_W  period in ticks.
- cfg_duty  in  CNT_W  PWM high time in ticks.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- pend  out  N_CH  shadow configuration waiting for commit.
- tick  out  1  prescaler tick, one-cycle pulse.
- led  out  N_CH  registered LED drive.

Behaviour:
- Reset is sys_rst, asynchronous, active-high, clock sys_clk. Reset values:
  - presc=0, tick=0, cfg_err=0.
  - Per channel: mode=OFF, period=0, duty=0, cnt=0, shadow cleared, pend=0, led=0.
  - Asserting reset mid-pattern returns to this state immediately.
- Prescaler:
  - presc counts 0..PRESC_DIV-1 and wraps.
  - tick is registered and is 1 for the cycle after presc==PRESC_DIV-1.
  - PRESC_DIV=1 gives tick=1 on every cycle out of reset.
- Write acceptance: a write is sampled on the edge where cfg_we=1. It is rejected if either:
  - cfg_ch >= N_CH, or
  - cfg_mode is BLINK/PWM and cfg_period==0.
- On reject: cfg_err=1 for one cycle, and no state changes.
- On accept: shadow[ch] is loaded with {mode, period, duty} and pend[ch]=1 from the next cycle.
- A second write while pend is set overwrites the shadow; pend stays 1.
- Commit condition, evaluated per channel each cycle: pend & (active mode is OFF/ON, or tick & cnt==period-1).
- At commit:
  - active registers are loaded from the shadow, cnt is set to 0 and pend is cleared.
  - For OFF/ON the commit occurs on the cycle after acceptance.
  - A write accepted on the commit cycle lands in the shadow; pend stays 1.
- Counter:
  - Only in BLINK/PWM: on tick, cnt increments, wrapping to 0 when cnt==period-1.
  - Otherwise cnt holds.
- LED output (registered; led reflects the active state one cycle later):
  - OFF: led=0.
  - ON: led=1.
  - BLINK: led toggles on tick & cnt==period-1. A commit into BLINK forces led=0. The output is a square wave with a full period of 2*period*PRESC_DIV cycles.
  - PWM: led <= (cnt < duty).
- PWM edge cases:
  - duty=0 gives constant 0.
  - duty >= period gives constant 1.
  - The duty value is not rejected.
- Width rule:
  - period and duty are unsigned CNT_W bits.
  - Comparisons are unsigned, with no wrap beyond period-1.
- Channels are fully independent and share only the prescaler and the config bus.

Decomposition:
- led_pkg contains:
  - typedef enum logic[1:0] led_mode_t {LED_OFF, LED_ON, LED_BLINK, LED_PWM}.
  - typedef struct packed led_cfg_t {mode, period, duty}, with CNT_W as a package parameter default.
- Sub-module led_channel: one channel, generated N_CH times.
  - Holds the active and shadow registers, pend, cnt and led.
  - Inputs: tick, a load strobe and led_cfg_t.
- The top level contains the prescaler, write decode and validation, and cfg_err.

Test Plan:
- Reset: hold sys_rst for 3 cycles, release. Required: led=0, pend=0, cfg_err=0; with PRESC_DIV=4, tick pulses every 4th cycle.
- ON write: write ch0 ON at edge t. Required: pend[0]=1 for exactly one cycle, led[0]=1 by edge t+2, other channels unaffected.
- BLINK: write ch1 BLINK period=3 (PRESC_DIV=4). Required: led[1] toggles every 12 cycles (24-cycle period). Then write ch1 PWM period=4 duty=1: pend[1] stays high until the next wrap, after which led[1] is high 4 of every 16 cycles.
- Invalid writes: cfg_ch=5 with N_CH=4, then ch2 BLINK period=0. Required: two one-cycle cfg_err pulses; pend and led unchanged.
- PWM edges and shadow overwrite: ch3 PWM period=4 with duty=0 gives constant 0, with duty=7 gives constant 1. Two writes issued back-to-back while pending: the last one wins.
- Asynchronous reset mid-BLINK: assert sys_rst between clock edges. Required: led and pend go to 0 immediately; after release, all channels are OFF.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED pattern bank: channel modes and the per-channel
// configuration record written through the config bus.
package led_pkg;

  localparam int LED_CNT_W = 26;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  typedef struct packed {
    led_mode_t              mode;
    logic [LED_CNT_W-1:0]   period;
    logic [LED_CNT_W-1:0]   duty;
  } led_cfg_t;

  // BLINK and PWM run a period counter; OFF and ON are static levels
  function automatic logic needs_period(input led_mode_t m);
    return (m == LED_BLINK) || (m == LED_PWM);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/active configuration, period counter and registered
// LED drive. New configurations take effect only at a period boundary.
module led_channel
  import led_pkg::*;
#(
  parameter int  CNT_W = LED_CNT_W,
  parameter type cfg_t = led_cfg_t
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_tick,
  input  logic i_load,
  input  cfg_t i_cfg,
  output logic o_pend,
  output logic o_led
);

  cfg_t             r_act;
  cfg_t             r_shd;
  logic             r_pend;
  logic             r_led;
  logic [CNT_W-1:0] r_cnt;

  logic w_cyclic;
  logic w_wrap;
  logic w_commit;

  // static modes commit at once; cyclic modes wait for the last tick of a period
  always_comb begin
    w_cyclic = needs_period(r_act.mode);
    w_wrap   = i_tick & w_cyclic & (r_cnt == (r_act.period - CNT_W'(1)));
    w_commit = r_pend & (~w_cyclic | w_wrap);
  end

  // shadow, pending flag and active configuration
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_shd  <= '0;
      r_act  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_load) begin
        r_shd <= i_cfg;
      end
      if (i_load) begin
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
      if (w_commit) begin
        r_act <= r_shd;
      end
    end
  end

  // period counter, restarted on every commit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (w_commit || w_wrap) begin
      r_cnt <= '0;
    end else if (i_tick && w_cyclic) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // LED drive from the active configuration; entering BLINK starts low
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_led <= 1'b0;
    end else if (w_commit && (r_shd.mode == LED_BLINK)) begin
      r_led <= 1'b0;
    end else begin
      case (r_act.mode)
        LED_OFF:   r_led <= 1'b0;
        LED_ON:    r_led <= 1'b1;
        LED_BLINK: r_led <= r_led ^ w_wrap;
        LED_PWM:   r_led <= (r_cnt < r_act.duty);
        default:   r_led <= 1'b0;
      endcase
    end
  end

  assign o_pend = r_pend;
  assign o_led  = r_led;

endmodule

// File: rtl/led_pattern_bank.sv
// Bank of N_CH LED drivers sharing a tick prescaler and one config write bus;
// writes are validated here and routed to the addressed channel.
module led_pattern_bank
  import led_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 26,
  parameter int PRESC_DIV = 50,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_err,
  output logic [N_CH-1:0]  pend,
  output logic             tick,
  output logic [N_CH-1:0]  led
);

  localparam int               PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [CH_W:0]    N_CH_L     = (CH_W + 1)'(N_CH);

  typedef struct packed {
    led_mode_t        mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
  } cfg_t;

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_err;

  led_mode_t w_mode;
  logic      w_ch_ok;
  logic      w_per_ok;
  logic      w_accept;
  logic      w_reject;
  cfg_t      w_cfg;

  // prescaler; tick is high for the cycle after the last count
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_presc == PRESC_LAST);
      r_presc <= (r_presc == PRESC_LAST) ? '0 : (r_presc + PW'(1));
    end
  end

  // write validation: channel must exist, cyclic modes need a nonzero period
  always_comb begin
    w_mode       = led_mode_t'(cfg_mode);
    w_ch_ok      = ({1'b0, cfg_ch} < N_CH_L);
    w_per_ok     = ~needs_period(w_mode) | (cfg_period != '0);
    w_accept     = cfg_we & w_ch_ok & w_per_ok;
    w_reject     = cfg_we & ~(w_ch_ok & w_per_ok);
    w_cfg.mode   = w_mode;
    w_cfg.period = cfg_period;
    w_cfg.duty   = cfg_duty;
  end

  // rejected writes produce a single-cycle error pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_channel #(
      .CNT_W (CNT_W),
      .cfg_t (cfg_t)
    ) u_ch (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .i_tick  (r_tick),
      .i_load  (w_accept && (cfg_ch == CH_W'(g))),
      .i_cfg   (w_cfg),
      .o_pend  (pend[g]),
      .o_led   (led[g])
    );
  end

  assign tick    = r_tick;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_led_pattern_bank.sv
// Directed and randomized bench for led_pattern_bank with a cycle-level
// behavioural model of every channel and the shared time base.
module tb_led_pattern_bank;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int PD  = 4;
  localparam int CHW = 3;

  logic           sys_clk;
  logic           sys_rst;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_mode;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_duty;
  logic           cfg_err;
  logic [NCH-1:0] pend;
  logic           tick;
  logic [NCH-1:0] led;

  led_pattern_bank #(.N_CH(NCH), .CNT_W(CW), .PRESC_DIV(PD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .pend(pend), .tick(tick), .led(led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // model state: active, shadow, counters
  int m_mode[NCH], m_per[NCH], m_duty[NCH], m_cnt[NCH], m_led[NCH];
  int s_mode[NCH], s_per[NCH], s_duty[NCH], m_pend[NCH];
  int m_n;
  int m_tick, m_err;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_cnt[i] = 0; m_led[i] = 0;
      s_mode[i] = 0; s_per[i] = 0; s_duty[i] = 0; m_pend[i] = 0;
    end
    m_n = 0; m_tick = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    int ch, md, per, dt;
    bit valid;
    if (sys_rst) begin
      model_reset();
      return;
    end
    ch = int'(cfg_ch); md = int'(cfg_mode); per = int'(cfg_period); dt = int'(cfg_duty);
    valid = (ch < NCH) && !(md >= 2 && per == 0);
    for (int i = 0; i < NCH; i++) begin
      bit wrap, commit, load;
      int nled;
      wrap   = (m_tick != 0) && (m_mode[i] >= 2) && (m_cnt[i] == m_per[i] - 1);
      commit = (m_pend[i] != 0) && ((m_mode[i] < 2) || wrap);
      load   = cfg_we && valid && (ch == i);
      if (commit && s_mode[i] == 2) nled = 0;
      else if (m_mode[i] == 0) nled = 0;
      else if (m_mode[i] == 1) nled = 1;
      else if (m_mode[i] == 2) nled = wrap ? 1 - m_led[i] : m_led[i];
      else nled = (m_cnt[i] < m_duty[i]) ? 1 : 0;
      m_led[i] = nled;
      if (commit) m_cnt[i] = 0;
      else if (m_mode[i] >= 2 && m_tick != 0) m_cnt[i] = wrap ? 0 : m_cnt[i] + 1;
      if (commit) begin
        m_mode[i] = s_mode[i]; m_per[i] = s_per[i]; m_duty[i] = s_duty[i];
      end
      if (load) begin
        s_mode[i] = md; s_per[i] = per; s_duty[i] = dt;
      end
      m_pend[i] = load ? 1 : (commit ? 0 : m_pend[i]);
    end
    m_err = (cfg_we && !valid) ? 1 : 0;
    m_n++;
    m_tick = ((m_n % PD) == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_led, e_pend;
    for (int i = 0; i < NCH; i++) begin
      e_led[i]  = (m_led[i] != 0);
      e_pend[i] = (m_pend[i] != 0);
    end
    check("led",     32'(led),     32'(e_led));
    check("pend",    32'(pend),    32'(e_pend));
    check("tick",    32'(tick),    32'(m_tick));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic wr(input int ch, input int md, input int per, input int dt);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_mode = 2'(md);
    cfg_period = CW'(per); cfg_duty = CW'(dt);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_pend_clear(input int ch, input int limit);
    int k = 0;
    while (pend[ch] && k < limit) begin
      step();
      k++;
    end
    check("pend_clear_timeout", 32'(pend[ch]), 32'd0);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (led[ch]) hi++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, k, ticks;
    logic lastv;
    int tq[$];

    sys_rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0;
    model_reset();

    // reset held for three cycles
    for (int i = 0; i < 3; i++) step();
    check("rst_led",  32'(led),     32'd0);
    check("rst_pend", 32'(pend),    32'd0);
    check("rst_err",  32'(cfg_err), 32'd0);
    sys_rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) ticks++;
    end
    check("tick_count_8cyc", 32'(ticks), 32'd2);

    // ON write on channel 0
    wr(0, 1, 0, 0);
    check("on_pend_t1", 32'(pend), 32'b00001);
    step();
    check("on_pend_t2", 32'(pend[0]), 32'd0);
    step();
    check("on_led_t2", 32'(led), 32'b00001);

    // BLINK period 3 on channel 1: toggle every 12 cycles
    wr(1, 2, 3, 0);
    lastv = led[1];
    for (int i = 0; i < 80; i++) begin
      step();
      if (led[1] !== lastv) begin
        tq.push_back(cyc);
        lastv = led[1];
      end
    end
    check("blink_enough_toggles", 32'(tq.size() >= 5), 32'd1);
    for (int i = 1; i < tq.size(); i++) check("blink_half_period", 32'(tq[i] - tq[i-1]), 32'd12);

    // switch channel 1 to PWM 1/4, committed at the next wrap
    wr(1, 3, 4, 1);
    check("pwm_pend_set", 32'(pend[1]), 32'd1);
    wait_pend_clear(1, 20);
    count_high(1, 16, hi);
    check("pwm_1of4_high", 32'(hi), 32'd4);

    // rejected writes: bad channel, then BLINK with zero period
    wr(5, 1, 3, 0);
    check("err_bad_ch", 32'(cfg_err), 32'd1);
    step();
    check("err_bad_ch_pulse", 32'(cfg_err), 32'd0);
    wr(2, 2, 0, 0);
    check("err_zero_per", 32'(cfg_err), 32'd1);
    check("err_no_pend", 32'(pend[2]), 32'd0);
    step();
    check("err_zero_per_pulse", 32'(cfg_err), 32'd0);

    // PWM extremes on channel 3
    wr(3, 3, 4, 0);
    wait_pend_clear(3, 20);
    for (int i = 0; i < 20; i++) begin
      step();
      check("pwm_duty0_low", 32'(led[3]), 32'd0);
    end
    wr(3, 3, 4, 7);
    wait_pend_clear(3, 20);
    for (int i = 0; i < 20; i++) begin
      step();
      check("pwm_duty7_high", 32'(led[3]), 32'd1);
    end

    // back-to-back writes while pending: the last one wins
    wr(3, 3, 4, 2);
    wr(3, 3, 4, 3);
    check("b2b_pend", 32'(pend[3]), 32'd1);
    wait_pend_clear(3, 20);
    count_high(3, 16, hi);
    check("b2b_last_wins", 32'(hi), 32'd12);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_ch     = CHW'($urandom_range(0, 7));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = CW'($urandom_range(0, 5));
      cfg_duty   = CW'($urandom_range(0, 6));
      step();
    end
    cfg_we = 1'b0;

    // asynchronous reset in the middle of a BLINK pattern with a write pending
    wr(1, 2, 2, 0);
    k = 0;
    while (!led[1] && k < 40) begin
      step();
      k++;
    end
    check("blink_high_before_rst", 32'(led[1]), 32'd1);
    wr(1, 3, 5, 1);
    check("pend_before_rst", 32'(pend[1]), 32'd1);
    #3 sys_rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_led",  32'(led),  32'd0);
    check("async_rst_pend", 32'(pend), 32'd0);
    step();
    step();
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("post_rst_all_off", 32'(led), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
